// File: rtl/sdc_butterfly.sv
// -----------------------------------------------------------------------------
// sdc_butterfly
//
// Radix-2 delay-commutator butterfly stage. It sits directly upstream of the
// twiddle rotator in the pipelined FFT.
//
// Input stream: one frame of N_POINTS complex samples, sent one word at a
// time. The real and imaginary words of each sample are interleaved, real
// word first, so a frame is 2*N_POINTS words long.
//
// Operation:
//   - The first half of the frame (words 0..N_POINTS-1) is written into a
//     delay buffer. No output is produced for these words.
//   - Each word of the second half (b) is paired with the word that arrived
//     N_POINTS words earlier (a).
//   - One cycle later the stage emits fmt(a+b) on line1 and fmt(a-b) on line2.
//   - Alongside the data it emits the real/imag phase flag and the twiddle
//     index k that the rotator and its coefficient source consume.
//
// Optional feature (macro SDC_BFLY_SCALE_EN):
//   defined   : fmt(x) = x >>> 1 (floor), truncated to width bits. This gives
//               a 1/2 scale per stage and can never overflow.
//   undefined : fmt(x) saturates x to the signed width-bit range. No scaling
//               is applied.
//
// Parameters:
//   width    - bits per data word (two's complement)
//   N_POINTS - complex samples per frame; must be a power of 2 and >= 2
//   IDX_W    - twiddle index width, clog2(N_POINTS/2) (minimum 1)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_data is accepted this cycle
//   in_sync   in   the accepted word is word 0 of a frame (ignored if !in_valid)
//   in_data   in   signed input word
//   line1     out  registered fmt(a+b)
//   line2     out  registered fmt(a-b)
//   sel_1     out  registered phase of line1/line2 (0 = real, 1 = imag)
//   tw_idx    out  registered twiddle index k of the word on line2
//   out_valid out  line1/line2/sel_1/tw_idx carry a new word this cycle
// -----------------------------------------------------------------------------
module sdc_butterfly #(
  parameter int width    = 12,
  parameter int N_POINTS = 8,
  parameter int IDX_W    = (N_POINTS > 2) ? $clog2(N_POINTS / 2) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [width-1:0] in_data,
  output logic [width-1:0] line1,
  output logic [width-1:0] line2,
  output logic             sel_1,
  output logic [IDX_W-1:0] tw_idx,
  output logic             out_valid
);

  // Buffer address width. The word counter has one more bit than the buffer
  // address; because 2*N_POINTS is a power of two, that extra MSB is set
  // exactly in the second half of the frame.
  localparam int AW = $clog2(N_POINTS);
  localparam int WW = AW + 1;
  localparam logic [WW-1:0] W_LAST = WW'(2 * N_POINTS - 1);

  logic [WW-1:0] w_reg;
  logic [WW-1:0] w_next;
  logic [WW-1:0] w_eff;
  logic [AW-1:0] slot;
  logic          second_half;

  logic signed [width-1:0] dly_mem [N_POINTS];
  logic signed [width-1:0] a_word;
  logic signed [width-1:0] b_word;
  logic signed [width:0]   sum_ext;
  logic signed [width:0]   diff_ext;

  logic [width-1:0] line1_reg,     line1_next;
  logic [width-1:0] line2_reg,     line2_next;
  logic             sel_1_reg,     sel_1_next;
  logic [IDX_W-1:0] tw_idx_reg,    tw_idx_next;
  logic             out_valid_reg, out_valid_next;
  logic [IDX_W-1:0] tw_calc;

  // Output formatting of a width+1 bit intermediate.
  function automatic logic [width-1:0] fmt(input logic signed [width:0] x);
`ifdef SDC_BFLY_SCALE_EN
    fmt = width'(x >>> 1);
`else
    if (x[width] != x[width-1]) begin
      fmt = x[width] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
    end else begin
      fmt = x[width-1:0];
    end
`endif
  endfunction

  // A sync on an accepted word overrides the running count for that word.
  // in_sync only matters together with in_valid, because nothing updates
  // without in_valid.
  assign w_eff       = in_sync ? '0 : w_reg;
  assign second_half = w_eff[WW-1];

  // The write slot (w) and the read slot (w - N_POINTS) share the same low
  // address bits, so one address serves both halves of the frame.
  assign slot = w_eff[AW-1:0];

  // k = n - N_POINTS/2, where n = w >> 1. In the second half this equals
  // slot >> 1.
  generate
    if (AW > 1) begin : g_tw_wide
      assign tw_calc = IDX_W'(slot[AW-1:1]);
    end else begin : g_tw_single
      assign tw_calc = '0;
    end
  endgenerate

  assign a_word   = dly_mem[slot];
  assign b_word   = $signed(in_data);
  assign sum_ext  = {a_word[width-1], a_word} + {b_word[width-1], b_word};
  assign diff_ext = {a_word[width-1], a_word} - {b_word[width-1], b_word};

  always_comb begin
    w_next         = w_reg;
    line1_next     = line1_reg;
    line2_next     = line2_reg;
    sel_1_next     = sel_1_reg;
    tw_idx_next    = tw_idx_reg;
    out_valid_next = 1'b0;
    if (in_valid) begin
      w_next = (w_eff == W_LAST) ? '0 : w_eff + 1'b1;
      if (second_half) begin
        line1_next     = fmt(sum_ext);
        line2_next     = fmt(diff_ext);
        sel_1_next     = w_eff[0];
        tw_idx_next    = tw_calc;
        out_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_reg         <= '0;
      line1_reg     <= '0;
      line2_reg     <= '0;
      sel_1_reg     <= 1'b0;
      tw_idx_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      w_reg         <= w_next;
      line1_reg     <= line1_next;
      line2_reg     <= line2_next;
      sel_1_reg     <= sel_1_next;
      tw_idx_reg    <= tw_idx_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Delay buffer. It has no reset, because every slot is rewritten in the
  // first half of a frame before the second half reads it.
  always_ff @(posedge clk) begin
    if (in_valid && !second_half) begin
      dly_mem[slot] <= b_word;
    end
  end

  assign line1     = line1_reg;
  assign line2     = line2_reg;
  assign sel_1     = sel_1_reg;
  assign tw_idx    = tw_idx_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_sdc_butterfly.sv
module tb_sdc_butterfly;

  localparam int WIDTH = 12;
  localparam int NP    = 8;
`ifdef SDC_BFLY_SCALE_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_sync = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] line1;
  logic [WIDTH-1:0] line2;
  logic             sel_1;
  logic [1:0]       tw_idx;
  logic             out_valid;

  sdc_butterfly #(.width(WIDTH), .N_POINTS(NP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_data  (in_data),
    .line1    (line1),
    .line2    (line2),
    .sel_1    (sel_1),
    .tw_idx   (tw_idx),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit v;
    bit s;
    int d;
    bit ov;
    int l1;
    int l2;
    int sel;
    int tw;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_no = 0;
  int   last_l1 = 0, last_l2 = 0, last_sel = 0, last_tw = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input bit v, input bit s, input int d, input bit ov,
                               input int l1, input int l2, input int sel, input int tw);
    vec_t e;
    e.v = v; e.s = s; e.d = d; e.ov = ov;
    e.l1 = l1; e.l2 = l2; e.sel = sel; e.tw = tw;
    vecs.push_back(e);
  endfunction

  // Ramp frame: sample n has re = 10n and im = -10n. For k = n - 4 the pair is
  // (sample k, sample k+4), so S_re = 20k+40, D_re = -40, S_im = -(20k+40),
  // D_im = 40.
  function automatic void add_ramp_word(input int w, input bit sync);
    int n, p, d, k, s;
    n = w / 2;
    p = w % 2;
    d = (p != 0) ? -10 * n : 10 * n;
    if (w < NP) begin
      push(1'b1, sync, d, 1'b0, 0, 0, 0, 0);
    end else begin
      k = n - NP / 2;
      s = 20 * k + 40;
      push(1'b1, sync, d, 1'b1, ((p != 0) ? -s : s) / SC,
           ((p != 0) ? 40 : -40) / SC, p, k);
    end
  endfunction

  function automatic void add_gap(input int cycles);
    for (int i = 0; i < cycles; i++) push(1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0);
  endfunction

  function automatic void add_ramp_frame(input bit sync, input bit gaps);
    for (int w = 0; w < 2 * NP; w++) begin
      if (gaps && w == 5)  add_gap(3);
      if (gaps && w == 11) add_gap(2);
      add_ramp_word(w, sync && (w == 0));
    end
  endfunction

  function automatic void add_extreme_frame();
    int a_tab [8];
    int b_tab [4];
    int s_tab [4];
    int d_tab [4];
    a_tab = '{2047, 2047, -2048, -2048, 2047, 2047, -2048, -2048};
    b_tab = '{2047, -2048, 2047, -2048};
`ifdef SDC_BFLY_SCALE_EN
    s_tab = '{2047, -1, -1, -2048};
    d_tab = '{0, 2047, -2048, 0};
`else
    s_tab = '{2047, -1, -1, -2048};
    d_tab = '{0, 2047, -2048, 0};
`endif
    for (int w = 0; w < NP; w++) push(1'b1, 1'b0, a_tab[w], 1'b0, 0, 0, 0, 0);
    for (int j = 0; j < NP; j++)
      push(1'b1, 1'b0, b_tab[j % 4], 1'b1, s_tab[j % 4], d_tab[j % 4], j % 2, j / 2);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, " line1"},  int'($signed(line1)), last_l1);
    check({tag, " line2"},  int'($signed(line2)), last_l2);
    check({tag, " sel_1"},  int'(sel_1), last_sel);
    check({tag, " tw_idx"}, int'(tw_idx), last_tw);
  endtask

  // Applies the queued vectors, one clock per record, and checks the outputs
  // #1 after the edge. line1/line2/sel_1/tw_idx are always compared with the
  // last expected valid output, which also covers the hold-during-gap case.
  task automatic run_vectors(input string tag);
    foreach (vecs[i]) begin
      in_valid = vecs[i].v;
      in_sync  = vecs[i].s;
      in_data  = WIDTH'(vecs[i].d);
      @(posedge clk);
      #1;
      if (vecs[i].ov) begin
        last_l1 = vecs[i].l1; last_l2 = vecs[i].l2;
        last_sel = vecs[i].sel; last_tw = vecs[i].tw;
      end
      $display("%s vec %0d: v=%0b s=%0b d=%0d -> ov=%0b l1=%0d l2=%0d sel=%0b tw=%0d",
               tag, vec_no, vecs[i].v, vecs[i].s, vecs[i].d, out_valid,
               $signed(line1), $signed(line2), sel_1, tw_idx);
      check({tag, " out_valid"}, int'(out_valid), int'(vecs[i].ov));
      check_outputs(tag);
      vec_no++;
    end
    vecs.delete();
    in_valid = 1'b0;
    in_sync  = 1'b0;
  endtask

  // Asserts reset away from any clock edge and checks that the outputs clear
  // without a clock. Reset is held for two edges and released #1 after an edge.
  task automatic async_reset(input string tag);
    #2;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    rst_n = 1'b0;
    #1;
    last_l1 = 0; last_l2 = 0; last_sel = 0; last_tw = 0;
    $display("%s: reset asserted -> ov=%0b l1=%0d l2=%0d sel=%0b tw=%0d",
             tag, out_valid, $signed(line1), $signed(line2), sel_1, tw_idx);
    check({tag, " out_valid"}, int'(out_valid), 0);
    check_outputs(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-up reset (no clock edge before the check)
    #2;
    rst_n = 1'b0;
    #1;
    check("por out_valid", int'(out_valid), 0);
    check_outputs("por");
    $display("por: ov=%0b l1=%0d l2=%0d", out_valid, $signed(line1), $signed(line2));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Sync-less first frame after reset, then a synced frame
    add_ramp_frame(1'b0, 1'b0);
    add_ramp_frame(1'b1, 1'b0);
    run_vectors("ramp");

    // Valid gaps at w=5 (3 cycles) and w=11 (2 cycles)
    add_ramp_frame(1'b0, 1'b1);
    run_vectors("gaps");

    add_extreme_frame();
    run_vectors("extreme");

    // Resync: 6 words of a frame, then a sync at what would have been w=6
    for (int w = 0; w < 6; w++) add_ramp_word(w, 1'b0);
    add_ramp_frame(1'b1, 1'b0);
    run_vectors("resync");

    // Reset during the second half (w=12 about to be sent), then a fresh frame
    for (int w = 0; w < 12; w++) add_ramp_word(w, 1'b0);
    run_vectors("pre_reset");
    async_reset("midreset");
    add_gap(2);
    add_ramp_frame(1'b0, 1'b0);
    run_vectors("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
